// File: rtl/sub32_pkg.sv
// Shared definitions for the slice-serial 32-bit subtractor.
// Provides the slice geometry, the index of the final slice and the FSM state type.
package sub32_pkg;

  localparam int unsigned SLICE_W    = 8;
  localparam int unsigned NUM_SLICES = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned DATA_W     = SLICE_W * NUM_SLICES;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/sub8_slice.sv
// Combinational 8-bit subtract slice: {bout, d} = a - b - bin.
// The borrow ripples through per-bit generate/propagate terms.
// Ports:
//   a, b  - slice operands
//   bin   - borrow into the slice
//   d     - slice difference
//   bout  - borrow out of the slice
//   eq    - a == b; every bit propagates the incoming borrow
module sub8_slice
  import sub32_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout,
  output logic               eq
);

  logic [SLICE_W-1:0] gen;  // bit borrows on its own: a=0, b=1
  logic [SLICE_W-1:0] prop; // bit passes the incoming borrow: a == b
  logic [SLICE_W:0]   brw;

  assign gen  = ~a & b;
  assign prop = ~(a ^ b);

  always_comb begin
    d      = '0;
    brw    = '0;
    brw[0] = bin;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      d[i]     = a[i] ^ b[i] ^ brw[i];
      brw[i+1] = gen[i] | (prop[i] & brw[i]);
    end
  end

  assign bout = brw[SLICE_W];
  assign eq   = &prop;

endmodule

// File: rtl/sub32_seq.sv
// Slice-serial 32-bit subtractor: diff = a - b - bin, one 8-bit slice per clock,
// least significant slice first, with the borrow carried in a register.
// Optional flags (zero/neg/ovf) are built only when SUB32_FLAGS_EN is defined;
// otherwise they are tied low.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid, in_ready   - operand handshake
//   a, b, bin            - minuend, subtrahend, borrow in
//   out_valid, out_ready - result handshake
//   diff, bout           - difference mod 2^32, borrow out (a < b + bin)
//   zero, neg, ovf       - diff == 0, diff[31], signed overflow
module sub32_seq
  import sub32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff,
  output logic              bout,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [DATA_W-1:0]  diff_q, diff_d;
  logic               bout_q, bout_d;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_d;
  logic               slice_bout, slice_eq;
  logic               last_slice;

  // Single slice datapath shared across all slice positions.
  assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

  sub8_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .bin  (borrow_q),
    .d    (slice_d),
    .bout (slice_bout),
    .eq   (slice_eq)
  );

  // Slice equality is not needed by the result path.
  logic unused_eq;
  assign unused_eq = slice_eq;

  assign last_slice = (state_q == StBusy) && (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        // diff is updated in place, so it holds mixed slices until DONE.
        diff_d[idx_q*SLICE_W +: SLICE_W] = slice_d;
        borrow_d = slice_bout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          bout_d  = slice_bout;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle) && rst_n;
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;

`ifdef SUB32_FLAGS_EN
  logic zero_q, neg_q, ovf_q;

  // Flags are captured together with bout from the final slice; lower slices are
  // already in diff_q at that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last_slice) begin
      zero_q <= (slice_d == '0) && (diff_q[DATA_W-SLICE_W-1:0] == '0);
      neg_q  <= slice_d[SLICE_W-1];
      ovf_q  <= (a_q[DATA_W-1] != b_q[DATA_W-1]) && (slice_d[SLICE_W-1] != a_q[DATA_W-1]);
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`else
  logic unused_last;
  assign unused_last = last_slice;

  assign zero = 1'b0;
  assign neg  = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_sub32_seq.sv
module tb_sub32_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        zero;
  logic        neg;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sub32_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Presents operands until in_ready, then lets one edge accept them.
  // t is the cycle number of the accepting edge; ok is 0 if in_ready never came.
  task automatic accept(input logic [31:0] aa, input logic [31:0] bb, input logic bi,
                        output bit ok, output int t);
    int n;
    n = 0;
    a = aa;
    b = bb;
    bin = bi;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    ok = in_ready;
    tick();
    t = cyc;
    in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid is seen (20 means timed out).
  task automatic wait_valid(output int lat);
    lat = 1;
    tick();
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    tick();
    tick();
    checks++;
    if ({out_valid, in_ready, bout, zero, neg, ovf} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got {ov,ir,bo,z,n,o}=%b want 000000",
               {out_valid, in_ready, bout, zero, neg, ovf});
    end
    checks++;
    if (diff !== 32'h0) begin
      errors++;
      $display("FAIL reset_diff got %h want 00000000", diff);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[6]   = '{32'h5, 32'h0, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h100};
    logic [31:0] vb[6]   = '{32'h3, 32'h1, 32'h1, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFF};
    logic        vbin[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] vd[6]   = '{32'h2, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};
    logic        vbo[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  vfl[6]  = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b010, 3'b100}; // {zero,neg,ovf}
    logic [2:0]  efl;
    bit ok;
    int t, lat;
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b0;
      accept(va[i], vb[i], vbin[i], ok, t);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL dir%0d_accept in_ready never high", i);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_busy_ready got %b want 0", i, in_ready);
      end
      wait_valid(lat);
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d want 4", i, lat);
      end
      checks++;
      if (diff !== vd[i] || bout !== vbo[i]) begin
        errors++;
        $display("FAIL dir%0d_result got diff=%h bout=%b want diff=%h bout=%b",
                 i, diff, bout, vd[i], vbo[i]);
      end
`ifdef SUB32_FLAGS_EN
      efl = vfl[i];
`else
      efl = 3'b000;
`endif
      checks++;
      if ({zero, neg, ovf} !== efl) begin
        errors++;
        $display("FAIL dir%0d_flags got %b want %b", i, {zero, neg, ovf}, efl);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_release got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int t, lat, bad;
    out_ready = 1'b0;
    accept(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, ok, t);
    wait_valid(lat);
    checks++;
    if (!ok || lat != 4) begin
      errors++;
      $display("FAIL bp_start got ok=%0d lat=%0d want ok=1 lat=4", ok, lat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      a = 32'h1111_1111 * i;
      b = 32'h0101_0101;
      bin = i[0];
      in_valid = i[0];
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 32'hD2FF_CEE1 || bout !== 1'b0)
        bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d bad cycles diff=%h want 0 bad diff=d2ffcee1", bad, diff);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    tick();
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_queue got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int t, lat;
    out_ready = 1'b0;
    accept(32'h1234_5678, 32'h1, 1'b0, ok, t);
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || diff !== 32'h0 || bout !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got ov=%b diff=%h bo=%b ir=%b want ov=0 diff=0 bo=0 ir=0",
               out_valid, diff, bout, in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_idle got ir=%b want 1", in_ready);
    end
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_discard got ov=%b want 0", out_valid);
    end
    accept(32'h100, 32'h1, 1'b0, ok, t);
    wait_valid(lat);
    checks++;
    if (lat != 4 || diff !== 32'hFF || bout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_next got lat=%0d diff=%h bo=%b want lat=4 diff=000000ff bo=0",
               lat, diff, bout);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[4] = '{32'h0000_0010, 32'h0001_0000, 32'h0, 32'hF000_0000};
    logic [31:0] vb[4] = '{32'h0000_0001, 32'h0000_0001, 32'h0, 32'h0F00_0000};
    logic [31:0] vd[4] = '{32'h0000_000F, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'hE100_0000};
    logic        vbo[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit ok;
    int t, lat, prev;
    prev = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      accept(va[i], vb[i], (i == 2) ? 1'b1 : 1'b0, ok, t);
      if (prev >= 0) begin
        checks++;
        if (t - prev != 6) begin
          errors++;
          $display("FAIL b2b%0d_spacing got %0d want 6", i, t - prev);
        end
      end
      prev = t;
      wait_valid(lat);
      checks++;
      if (lat != 4 || diff !== vd[i] || bout !== vbo[i]) begin
        errors++;
        $display("FAIL b2b%0d_result got lat=%0d diff=%h bo=%b want lat=4 diff=%h bo=%b",
                 i, lat, diff, bout, vd[i], vbo[i]);
      end
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic        rbin;
    logic [32:0] exp;
    bit ok;
    int t, lat, hold, prev, bad;
    prev = -100;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      rbin = 1'($urandom_range(0, 1));
      exp = {1'b0, ra} - {1'b0, rb} - {32'b0, rbin};
      accept(ra, rb, rbin, ok, t);
      a = $urandom;
      b = $urandom;
      checks++;
      if (!ok || t - prev < 6) begin
        errors++;
        $display("FAIL rnd%0d_accept got ok=%0d spacing=%0d want ok=1 spacing>=6",
                 i, ok, t - prev);
      end
      prev = t;
      wait_valid(lat);
      checks++;
      if (lat != 4 || {bout, diff} !== exp) begin
        errors++;
        $display("FAIL rnd%0d_result a=%h b=%h bin=%b got lat=%0d bo=%b diff=%h want lat=4 %h",
                 i, ra, rb, rbin, lat, bout, diff, exp);
      end
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) begin
        tick();
        if (out_valid !== 1'b1 || {bout, diff} !== exp) bad++;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rnd_hold got %0d unstable cycles want 0", bad);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
